// File: rtl/alarm_pkg.sv
// Shared alarm definitions: FSM state encoding, default durations and BCD digit fields.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RINGING = 2'b01,
        SNOOZE  = 2'b10
    } alarm_state_t;

    localparam int unsigned RING_SECS_DEF   = 60;
    localparam int unsigned SNOOZE_SECS_DEF = 300;
    localparam int unsigned TMR_W_DEF       = 9;

    // BCD HH:MM digit fields, shared with the alarm counter and the display mux
    localparam int unsigned HT_MSB = 15;
    localparam int unsigned HT_LSB = 12;
    localparam int unsigned HU_MSB = 11;
    localparam int unsigned HU_LSB = 8;
    localparam int unsigned MT_MSB = 7;
    localparam int unsigned MT_LSB = 4;
    localparam int unsigned MU_MSB = 3;
    localparam int unsigned MU_LSB = 0;
    localparam int unsigned DIGITS_W = 16;

endpackage

// File: rtl/alarm_sec_timer.sv
// Seconds up-counter shared by ring and snooze: clear, per-tick increment, terminal-count flag.
module alarm_sec_timer #(
    parameter int unsigned TMR_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [TMR_W-1:0] limit,
    output logic             tc_c
);

    logic [TMR_W-1:0] count_q;

    // Count seconds; clear has priority over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + TMR_W'(1);
        end
    end

    // Terminal count against the runtime limit of the active phase
    assign tc_c = (count_q == limit);

endmodule

// File: rtl/alarm_ring_controller.sv
// Alarm ring controller: HH:MM match detection, ring/snooze/timeout sequencing,
// buzzer and 1 Hz alarm LED. Optional snooze is enabled by defining ALARM_SNOOZE_EN.
module alarm_ring_controller
    import alarm_pkg::*;
#(
    parameter int unsigned RING_SECS   = RING_SECS_DEF,
    parameter int unsigned SNOOZE_SECS = SNOOZE_SECS_DEF,
    parameter int unsigned TMR_W       = TMR_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1hz,
    input  logic        alarm_en,
    input  logic [15:0] clock_digits,
    input  logic [15:0] alarm_digits,
    input  logic        stop_btn,
    input  logic        snooze_btn,
    output logic        buzzer,
    output logic        alarm_led,
    output logic        ringing,
    output logic        snoozing
);

    alarm_state_t     state_q, state_d;
    logic             match_c, match_q, trigger_c;
    logic             tmr_clr_c, tmr_inc_c, tmr_tc_c;
    logic             led_d;
    logic [TMR_W-1:0] tmr_limit_c;
    logic             snooze_req_c;

    assign match_c   = (clock_digits == alarm_digits);
    assign trigger_c = match_c & ~match_q & alarm_en;

`ifdef ALARM_SNOOZE_EN
    assign snooze_req_c = snooze_btn;
`else
    logic unused_snooze_btn;
    assign unused_snooze_btn = snooze_btn;
    assign snooze_req_c      = 1'b0;
`endif

    assign tmr_limit_c = (state_q == SNOOZE) ? TMR_W'(SNOOZE_SECS - 1)
                                             : TMR_W'(RING_SECS - 1);

    alarm_sec_timer #(
        .TMR_W (TMR_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (tmr_clr_c),
        .inc   (tmr_inc_c),
        .limit (tmr_limit_c),
        .tc_c  (tmr_tc_c)
    );

    // Match edge detector; resets high so a match present at reset release is not new
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q <= 1'b1;
        end else begin
            match_q <= match_c;
        end
    end

    // State and output registers, loaded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            buzzer    <= 1'b0;
            ringing   <= 1'b0;
            alarm_led <= 1'b0;
        end else begin
            state_q   <= state_d;
            buzzer    <= (state_d == RINGING);
            ringing   <= (state_d == RINGING);
            alarm_led <= led_d;
        end
    end

`ifdef ALARM_SNOOZE_EN
    // Snooze indicator register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snoozing <= 1'b0;
        end else begin
            snoozing <= (state_d == SNOOZE);
        end
    end
`else
    assign snoozing = 1'b0;
`endif

    // Next-state, timer control and LED next value
    always_comb begin
        state_d   = state_q;
        tmr_clr_c = 1'b0;
        tmr_inc_c = 1'b0;
        led_d     = 1'b0;

        if (!alarm_en) begin
            state_d   = IDLE;
            tmr_clr_c = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tmr_clr_c = 1'b1;
                    if (trigger_c) begin
                        state_d = RINGING;
                    end
                end
                RINGING: begin
                    if (stop_btn) begin
                        state_d = IDLE;
                    end else if (snooze_req_c) begin
                        state_d   = SNOOZE;
                        tmr_clr_c = 1'b1;
                    end else if (tick_1hz && tmr_tc_c) begin
                        state_d = IDLE;
                    end else if (tick_1hz) begin
                        tmr_inc_c = 1'b1;
                    end
                end
                SNOOZE: begin
                    if (stop_btn) begin
                        state_d = IDLE;
                    end else if (tick_1hz && tmr_tc_c) begin
                        state_d   = RINGING;
                        tmr_clr_c = 1'b1;
                    end else if (tick_1hz) begin
                        tmr_inc_c = 1'b1;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    tmr_clr_c = 1'b1;
                end
            endcase
        end

        // LED lights on ring entry, then toggles each second while ringing
        if (state_d == RINGING) begin
            if (state_q != RINGING) begin
                led_d = 1'b1;
            end else if (tick_1hz) begin
                led_d = ~alarm_led;
            end else begin
                led_d = alarm_led;
            end
        end
    end

endmodule

// File: tb/tb_alarm_ring_controller.sv
// Directed self-checking bench for alarm_ring_controller (default durations 60 s / 300 s).
module tb_alarm_ring_controller;

    localparam int unsigned RING   = 60;
    localparam int unsigned SNOOZE = 300;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick_1hz;
    logic        alarm_en;
    logic [15:0] clock_digits;
    logic [15:0] alarm_digits;
    logic        stop_btn;
    logic        snooze_btn;
    logic        buzzer;
    logic        alarm_led;
    logic        ringing;
    logic        snoozing;

    int n_checks = 0;
    int n_fail   = 0;

    alarm_ring_controller dut (
        .clk          (clk),
        .rst          (rst),
        .tick_1hz     (tick_1hz),
        .alarm_en     (alarm_en),
        .clock_digits (clock_digits),
        .alarm_digits (alarm_digits),
        .stop_btn     (stop_btn),
        .snooze_btn   (snooze_btn),
        .buzzer       (buzzer),
        .alarm_led    (alarm_led),
        .ringing      (ringing),
        .snoozing     (snoozing)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic one_tick();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) one_tick();
    endtask

    // Produce a fresh match edge: leave the alarm minute, then return to it
    task automatic retrigger();
        clock_digits = 16'h0731;
        step();
        clock_digits = 16'h0730;
        step();
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ringing"},  ringing,   1'b0);
        chk({tag, "_buzzer"},   buzzer,    1'b0);
        chk({tag, "_led"},      alarm_led, 1'b0);
        chk({tag, "_snoozing"}, snoozing,  1'b0);
    endtask

    initial begin
        rst          = 1'b1;
        tick_1hz     = 1'b0;
        alarm_en     = 1'b1;
        clock_digits = 16'h0729;
        alarm_digits = 16'h0730;
        stop_btn     = 1'b0;
        snooze_btn   = 1'b0;
        step();
        step();
        chk_idle("reset");
        rst = 1'b0;
        step();
        chk_idle("post_reset");

        // New match: registered outputs rise only after the sampling edge
        clock_digits = 16'h0730;
        #1;
        chk("no_comb_path", ringing, 1'b0);
        step();
        chk("trig_ringing", ringing, 1'b1);
        chk("trig_buzzer",  buzzer,  1'b1);
        chk("trig_led",     alarm_led, 1'b1);
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        chk("led_tick1", alarm_led, 1'b0);
        step();
        chk("led_hold", alarm_led, 1'b0);
        one_tick();
        chk("led_tick2", alarm_led, 1'b1);

        // Auto-timeout on exactly the 60th tick
        ticks(RING - 3);
        chk("ring_59", ringing, 1'b1);
        one_tick();
        chk_idle("timeout");
        ticks(3);
        chk("persist_no_rering", ringing, 1'b0);
        retrigger();
        chk("rering", ringing, 1'b1);

        // Snooze after 5 ticks
        ticks(5);
        snooze_btn = 1'b1;
        step();
        snooze_btn = 1'b0;
`ifdef ALARM_SNOOZE_EN
        chk("snz_snoozing", snoozing, 1'b1);
        chk("snz_buzzer",   buzzer,   1'b0);
        chk("snz_led",      alarm_led, 1'b0);
        ticks(SNOOZE - 1);
        chk("snz_299", snoozing, 1'b1);
        chk("snz_299_ring", ringing, 1'b0);
        one_tick();
        chk("snz_rering", ringing, 1'b1);
        chk("snz_rering_led", alarm_led, 1'b1);
        chk("snz_clear", snoozing, 1'b0);
`else
        chk("nosnz_ringing",  ringing,  1'b1);
        chk("nosnz_snoozing", snoozing, 1'b0);
        chk("nosnz_buzzer",   buzzer,   1'b1);
`endif

        // Stop and snooze together: stop wins
        stop_btn   = 1'b1;
        snooze_btn = 1'b1;
        step();
        stop_btn   = 1'b0;
        snooze_btn = 1'b0;
        chk_idle("stop_and_snooze");

        // Buttons in IDLE are ignored
        snooze_btn = 1'b1;
        step();
        snooze_btn = 1'b0;
        stop_btn   = 1'b1;
        step();
        stop_btn   = 1'b0;
        chk_idle("idle_buttons");

        // Stop on the timeout tick
        retrigger();
        ticks(RING - 1);
        chk("stop_tc_pre", ringing, 1'b1);
        tick_1hz = 1'b1;
        stop_btn = 1'b1;
        step();
        tick_1hz = 1'b0;
        stop_btn = 1'b0;
        chk_idle("stop_on_tc");

        // Alarm time edits mid-ring do not end the ring; alarm_en drop clears
        retrigger();
        alarm_digits = 16'h0800;
        step();
        chk("alarm_edit_ringing", ringing, 1'b1);
        alarm_en = 1'b0;
        #1;
        chk("en_drop_same_cycle", ringing, 1'b1);
        step();
        chk_idle("en_drop");
        alarm_en = 1'b1;
        alarm_digits = 16'h0730;
        step();

        // Reset release while matching does not ring
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();
        chk_idle("reset_on_match");

        // Async reset mid-snooze (mid-ring without snooze), then timer restarts from 0
        retrigger();
        ticks(10);
`ifdef ALARM_SNOOZE_EN
        snooze_btn = 1'b1;
        step();
        snooze_btn = 1'b0;
        ticks(20);
        chk("pre_rst_snoozing", snoozing, 1'b1);
`else
        chk("pre_rst_ringing", ringing, 1'b1);
`endif
        #2 rst = 1'b1;
        #1;
        chk_idle("async_rst");
        #1 rst = 1'b0;
        step();
        retrigger();
        chk("post_rst_ring", ringing, 1'b1);
        ticks(RING - 1);
        chk("post_rst_59", ringing, 1'b1);
        one_tick();
        chk("post_rst_60", ringing, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
